// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : FSM sequencer for a multi-cycle RV32I datapath sharing one memory
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_instr,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       pc_src,
  output logic [1:0]       selSrc,
  output logic [3:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t           cur;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic [6:0]       f7_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic op_valid(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: op_valid = 1'b1;
      default:                                                  op_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_r(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      {F7_ZERO, 3'b000}: alu_r = ALU_ADD;
      {F7_ALT,  3'b000}: alu_r = ALU_SUB;
      {F7_ZERO, 3'b111}: alu_r = ALU_AND;
      {F7_ZERO, 3'b110}: alu_r = ALU_OR;
      {F7_ZERO, 3'b100}: alu_r = ALU_XOR;
      {F7_ZERO, 3'b001}: alu_r = ALU_SLL;
      {F7_ZERO, 3'b101}: alu_r = ALU_SRL;
      {F7_ALT,  3'b101}: alu_r = ALU_SRA;
      {F7_ZERO, 3'b010}: alu_r = ALU_SLT;
      {F7_ZERO, 3'b011}: alu_r = ALU_SLTU;
      default:           alu_r = ALU_ADD;
    endcase
  endfunction

  // Immediate forms ignore funct7 except to pick logical vs arithmetic right shift.
  function automatic logic [3:0] alu_i(input logic [6:0] f7, input logic [2:0] f3);
    case (f3)
      3'b000:  alu_i = ALU_ADD;
      3'b111:  alu_i = ALU_AND;
      3'b110:  alu_i = ALU_OR;
      3'b100:  alu_i = ALU_XOR;
      3'b001:  alu_i = ALU_SLL;
      3'b101:  alu_i = (f7 == F7_ZERO) ? ALU_SRL : ALU_SRA;
      3'b010:  alu_i = ALU_SLT;
      3'b011:  alu_i = ALU_SLTU;
      default: alu_i = ALU_ADD;
    endcase
  endfunction

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;

  always_comb begin
    is_r      = (op_q == OP_R);
    is_i      = (op_q == OP_I);
    is_load   = (op_q == OP_LOAD);
    is_store  = (op_q == OP_STORE);
    is_branch = (op_q == OP_BRANCH);
    is_jal    = (op_q == OP_JAL);
    is_jalr   = (op_q == OP_JALR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (mem_ready) cur <= S_DECODE;
        end
        S_DECODE: begin
          op_q <= opcode;
          f3_q <= funct3;
          f7_q <= funct7;
          if (op_valid(opcode)) begin
            cur <= S_EXEC;
          end else begin
            cur       <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            cur   <= S_FETCH;
            cnt_q <= cnt_q + 1'b1;
          end else if (is_load || is_store) begin
            cur <= S_MEM;
          end else if (is_r || is_i || is_jal || is_jalr) begin
            cur <= S_WB;
          end else begin
            cur <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_load) begin
              cur <= S_WB;
            end else begin
              cur   <= S_FETCH;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WB: begin
          cur   <= S_FETCH;
          cnt_q <= cnt_q + 1'b1;
        end
        S_TRAP: begin
          cur <= S_TRAP;
        end
        default: begin
          cur <= S_FETCH;
        end
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    pc_src       = 2'b00;
    selSrc       = 2'b00;
    ALUOp        = ALU_ADD;
    RegWrite     = 1'b0;
    wb_sel       = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        IRWrite      = mem_ready;
        PCWrite      = mem_ready;
      end
      S_EXEC: begin
        if (is_r) begin
          ALUOp = alu_r(f7_q, f3_q);
        end else if (is_i) begin
          selSrc = 2'b01;
          ALUOp  = alu_i(f7_q, f3_q);
        end else if (is_load || is_store) begin
          selSrc = 2'b01;
        end else if (is_branch) begin
          ALUOp   = ALU_SUB;
          PCWrite = branch_taken;
          pc_src  = branch_taken ? 2'b01 : 2'b00;
        end else if (is_jal) begin
          PCWrite = 1'b1;
          pc_src  = 2'b01;
        end else if (is_jalr) begin
          selSrc  = 2'b01;
          PCWrite = 1'b1;
          pc_src  = 2'b10;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (is_load)                wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
      end
      default: begin
      end
    endcase
    // Reset must suppress every write strobe, even before the state settles.
    if (rst) begin
      mem_we   = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign state   = cur;
  assign illegal = illegal_q;
  assign instret = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, mem_is_instr, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]  pc_src, selSrc, wb_sel;
  logic [3:0]  ALUOp;
  logic [2:0]  state;
  logic [31:0] instret;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .pc_src(pc_src), .selSrc(selSrc),
    .ALUOp(ALUOp), .RegWrite(RegWrite), .wb_sel(wb_sel), .illegal(illegal),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and land mid-cycle, away from both edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
    mem_ready = 1'b0; branch_taken = 1'b0;
    #12;
    check("rst_state",   {29'd0, state}, 32'd0);
    check("rst_fetchreq", {30'd0, mem_req, mem_is_instr}, 32'h3);
    check("rst_strobes", {28'd0, IRWrite, PCWrite, RegWrite, mem_we}, 32'h0);
    check("rst_cnt",     instret, 32'd0);
    check("rst_ill",     {31'd0, illegal}, 32'd0);
    rst = 1'b0;

    // add x3,x1,x2 with zero wait states
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1;
    #1;
    check("add_fetch", {29'd0, IRWrite, PCWrite, mem_we}, 32'h6);
    check("add_fetch_pcsrc", {30'd0, pc_src}, 32'd0);
    tick(); check("add_dec", {29'd0, state}, 32'd1);
    tick(); check("add_exec", {29'd0, state}, 32'd2);
    check("add_aluop", {28'd0, ALUOp}, 32'h0);
    check("add_selsrc", {30'd0, selSrc}, 32'd0);
    tick(); check("add_wb", {29'd0, state}, 32'd4);
    check("add_wb_ctl", {29'd0, RegWrite, wb_sel}, 32'h4);
    check("add_wb_cnt", instret, 32'd0);
    tick(); check("add_done", {29'd0, state}, 32'd0);
    check("add_cnt", instret, 32'd1);

    // lw with 2 fetch waits and 3 memory waits
    mem_ready = 1'b0; opcode = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 2; i++) begin
      #1; check("lw_fwait", {29'd0, mem_req, mem_is_instr, IRWrite}, 32'h6);
      tick(); check("lw_fwait_st", {29'd0, state}, 32'd0);
    end
    mem_ready = 1'b1; #1;
    check("lw_fetch", {29'd0, mem_req, IRWrite, PCWrite}, 32'h7);
    tick(); check("lw_dec", {29'd0, state}, 32'd1);
    tick(); check("lw_exec", {26'd0, selSrc, ALUOp}, 32'h10);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1; check("lw_mwait", {28'd0, state, mem_req}, {28'd0, 3'd3, 1'b1});
      check("lw_mwait_ctl", {30'd0, mem_we, mem_is_instr}, 32'd0);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("lw_mem_rdy", {28'd0, state, mem_req}, {28'd0, 3'd3, 1'b1});
    tick(); check("lw_wb", {26'd0, state, RegWrite, wb_sel}, {26'd0, 3'd4, 1'b1, 2'b01});
    tick(); check("lw_done", {29'd0, state}, 32'd0);
    check("lw_cnt", instret, 32'd2);

    // beq taken then not taken
    opcode = 7'b1100011; funct3 = 3'b000;
    tick(); tick();
    branch_taken = 1'b1; #1;
    check("beqt_exec", {29'd0, state}, 32'd2);
    check("beqt_pc", {29'd0, PCWrite, pc_src}, 32'h5);
    check("beqt_alu", {26'd0, selSrc, ALUOp}, 32'h01);
    tick(); check("beqt_done", {29'd0, state}, 32'd0);
    check("beqt_cnt", instret, 32'd3);
    tick(); tick();
    branch_taken = 1'b0; #1;
    check("beqn_exec", {29'd0, state}, 32'd2);
    check("beqn_pc", {31'd0, PCWrite}, 32'd0);
    tick(); check("beqn_done", {29'd0, state}, 32'd0);
    check("beqn_cnt", instret, 32'd4);

    // srai, with IR funct changed after decode to confirm latching
    opcode = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0100000;
    tick(); tick();
    funct7 = 7'b0000000; funct3 = 3'b000; opcode = 7'b0000000;
    check("srai_exec", {26'd0, selSrc, ALUOp}, 32'h17);
    tick(); check("srai_wb", {26'd0, state, RegWrite, wb_sel}, {26'd0, 3'd4, 1'b1, 2'b00});
    tick(); check("srai_cnt", instret, 32'd5);
    opcode = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0000000;
    tick(); tick();
    check("srli_exec", {26'd0, selSrc, ALUOp}, 32'h16);
    tick(); tick(); check("srli_cnt", instret, 32'd6);

    // jalr
    opcode = 7'b1100111; funct3 = 3'b000;
    tick(); tick();
    check("jalr_exec", {29'd0, PCWrite, pc_src}, 32'h6);
    check("jalr_alu", {26'd0, selSrc, ALUOp}, 32'h10);
    tick(); check("jalr_wb", {26'd0, state, RegWrite, wb_sel}, {26'd0, 3'd4, 1'b1, 2'b10});
    tick(); check("jalr_cnt", instret, 32'd7);

    // illegal opcode -> TRAP, held for 20 cycles with memory answering
    opcode = 7'b0001111;
    tick(); check("trap_dec", {29'd0, state}, 32'd1);
    tick(); check("trap_ill", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("trap_hold", {24'd0, state, mem_req, IRWrite, PCWrite, RegWrite, mem_we},
            {24'd0, 3'd5, 5'b00000});
      tick();
    end
    check("trap_cnt", instret, 32'd7);
    check("trap_sticky", {31'd0, illegal}, 32'd1);
    rst = 1'b1; #1;
    check("trap_rst", {28'd0, state, illegal}, 32'd0);
    check("trap_rst_cnt", instret, 32'd0);
    tick(); rst = 1'b0;

    // store completing normally
    opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    tick(); tick();
    check("sw_exec", {26'd0, selSrc, ALUOp}, 32'h10);
    mem_ready = 1'b0;
    tick(); #1;
    check("sw_mem", {26'd0, state, mem_req, mem_we, mem_is_instr}, {26'd0, 3'd3, 3'b110});
    check("sw_mem_strb", {29'd0, IRWrite, PCWrite, RegWrite}, 32'd0);
    mem_ready = 1'b1; #1;
    tick(); check("sw_done", {29'd0, state}, 32'd0);
    check("sw_cnt", instret, 32'd1);

    // store interrupted by reset during its MEM wait
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick(); #1;
    check("swr_wait", {28'd0, state, mem_we}, {28'd0, 3'd3, 1'b1});
    rst = 1'b1; #1;
    check("swr_rst", {28'd0, state, mem_we}, 32'd0);
    check("swr_rst_ill", {31'd0, illegal}, 32'd0);
    check("swr_rst_cnt", instret, 32'd0);
    tick(); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
